// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared states and encodings for the MEM-stage byte sequencer
package mem_seq_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic SIZE_BYTE      = 1'b0;
    localparam logic SIZE_WORD      = 1'b1;
    localparam logic RW_READ        = 1'b0;
    localparam logic RW_WRITE       = 1'b1;
    localparam int   BYTES_PER_WORD = 4;
endpackage

// File: rtl/mem_lane_select.sv
// rtl/mem_lane_select.sv - big-endian byte lane steering for write data and read assembly
module mem_lane_select
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        cnt,
    input  logic              size,
    input  logic [DATA_W-1:0] di,
    input  logic [DATA_W-1:0] asm_q,
    input  logic [7:0]        rdata,
    output logic [7:0]        wbyte,
    output logic [DATA_W-1:0] asm_next
);
    logic [1:0] lane;
    logic [4:0] lsb;

    always_comb begin
        lane     = 2'd3 - cnt;
        lsb      = {lane, 3'b000};
        wbyte    = di[7:0];
        asm_next = {{(DATA_W-8){1'b0}}, rdata};
        // Word transfers walk from the MSB lane down: byte at the base address is bits 31:24.
        if (size == SIZE_WORD) begin
            wbyte              = di[lsb +: 8];
            asm_next           = asm_q;
            asm_next[lsb +: 8] = rdata;
        end
    end
endmodule

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - executes byte/word MEM-stage requests one RAM byte per cycle
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req,
    input  logic              rw,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] do_out,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, last_q;
    logic              rw_q, size_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] di_q, asm_q, asm_next;
    logic [7:0]        wbyte;
    logic              misalign;

    assign misalign = (size == SIZE_WORD) && (addr[1:0] != 2'b00);

    mem_lane_select #(.DATA_W(DATA_W)) u_lane (
        .cnt      (cnt_q),
        .size     (size_q),
        .di       (di_q),
        .asm_q    (asm_q),
        .rdata    (mem_rdata),
        .wbyte    (wbyte),
        .asm_next (asm_next)
    );

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            asm_q   <= '0;
            do_out  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        rw_q   <= rw;
                        size_q <= size;
                        addr_q <= addr;
                        di_q   <= di;
                        err_q  <= misalign;
                        cnt_q  <= 2'd0;
                        last_q <= (size == SIZE_WORD) ? 2'd3 : 2'd0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (rw_q == RW_READ) begin
                        asm_q <= asm_next;
                        // Final byte merges straight into do_out on the edge that enters DONE.
                        if (cnt_q == last_q) begin
                            do_out <= asm_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = misalign ? DONE : ACCESS;
            ACCESS:  if (cnt_q == last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mem_en    = (state_q == ACCESS);
        mem_we    = mem_en && (rw_q == RW_WRITE);
        mem_addr  = mem_en ? (addr_q + ADDR_W'(cnt_q)) : '0;
        mem_wdata = mem_en ? wbyte : 8'h00;
        done      = (state_q == DONE);
        err       = done && err_q;
    end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - directed self-checking bench for mem_byte_sequencer
module tb_mem_byte_sequencer;
    logic        clk = 1'b0;
    logic        R;
    logic        req, rw, size;
    logic [7:0]  addr;
    logic [31:0] di;
    logic        busy, done, err;
    logic [31:0] do_out;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  ram [0:255];
    logic        preload;

    int          n_cmp = 0;
    int          n_bad = 0;

    int          lat, n_busy, n_acc, n_done;
    logic        err_seen;
    logic [7:0]  acc_addr [0:3];

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .R         (R),
        .req       (req),
        .rw        (rw),
        .size      (size),
        .addr      (addr),
        .di        (di),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .do_out    (do_out),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem_en ? ram[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram[52]  <= 8'h80; ram[53]  <= 8'h12; ram[54]  <= 8'h34; ram[55]  <= 8'h56;
            ram[56]  <= 8'hF0; ram[57]  <= 8'h5A; ram[58]  <= 8'h00; ram[59]  <= 8'h5C;
            ram[66]  <= 8'hA6; ram[67]  <= 8'hA7;
            ram[252] <= 8'h01; ram[253] <= 8'h02; ram[254] <= 8'h03; ram[255] <= 8'h04;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and observes a fixed 12-cycle window after acceptance edge E0.
    task automatic run_req(input logic r_w, input logic sz, input logic [7:0] a,
                           input logic [31:0] d, input bit pulse2);
        @(negedge clk);
        req = 1'b1; rw = r_w; size = sz; addr = a; di = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1; n_busy = 0; n_acc = 0; n_done = 0; err_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (busy) n_busy++;
            if (mem_en) begin
                if (n_acc < 4) acc_addr[n_acc] = mem_addr;
                n_acc++;
            end
            if (done) begin
                if (lat < 0) begin
                    lat      = k;
                    err_seen = err;
                end
                n_done++;
            end
            if (pulse2 && k == 1) req = 1'b1;
            if (pulse2 && k == 2) req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        R = 1'b1; req = 1'b0; rw = 1'b0; size = 1'b0; addr = 8'h00; di = 32'h0;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_done",   32'(done),      32'h0);
        check("rst_err",    32'(err),       32'h0);
        check("rst_mem_en", 32'(mem_en),    32'h0);
        check("rst_mem_we", 32'(mem_we),    32'h0);
        check("rst_maddr",  32'(mem_addr),  32'h0);
        check("rst_wdata",  32'(mem_wdata), 32'h0);
        check("rst_do_out", do_out,         32'h0);
        @(negedge clk);
        R = 1'b0;

        run_req(1'b0, 1'b1, 8'd52, 32'h0, 1'b0);
        check("wr52_lat",   32'(lat),         32'd4);
        check("wr52_busy",  32'(n_busy),      32'd5);
        check("wr52_nacc",  32'(n_acc),       32'd4);
        check("wr52_a0",    32'(acc_addr[0]), 32'd52);
        check("wr52_a1",    32'(acc_addr[1]), 32'd53);
        check("wr52_a2",    32'(acc_addr[2]), 32'd54);
        check("wr52_a3",    32'(acc_addr[3]), 32'd55);
        check("wr52_data",  do_out,           32'h80123456);
        check("wr52_err",   32'(err_seen),    32'h0);

        run_req(1'b0, 1'b0, 8'd56, 32'hFFFFFFFF, 1'b0);
        check("br56_lat",   32'(lat),         32'd1);
        check("br56_nacc",  32'(n_acc),       32'd1);
        check("br56_busy",  32'(n_busy),      32'd2);
        check("br56_data",  do_out,           32'h000000F0);

        run_req(1'b1, 1'b0, 8'd58, 32'hAABBCC07, 1'b0);
        check("bw58_lat",   32'(lat),         32'd1);
        check("bw58_ram58", 32'(ram[58]),     32'h07);
        check("bw58_ram57", 32'(ram[57]),     32'h5A);
        check("bw58_ram59", 32'(ram[59]),     32'h5C);
        check("bw58_dout",  do_out,           32'h000000F0);

        run_req(1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 1'b0);
        check("ww60_lat",   32'(lat),         32'd4);
        check("ww60_ram60", 32'(ram[60]),     32'hDE);
        check("ww60_ram61", 32'(ram[61]),     32'hAD);
        check("ww60_ram63", 32'(ram[63]),     32'hEF);
        run_req(1'b0, 1'b1, 8'd60, 32'h0, 1'b0);
        check("wr60_data",  do_out,           32'hDEADBEEF);

        run_req(1'b0, 1'b1, 8'd54, 32'h0, 1'b0);
        check("mis_lat",    32'(lat),         32'd0);
        check("mis_err",    32'(err_seen),    32'h1);
        check("mis_nacc",   32'(n_acc),       32'd0);
        check("mis_busy",   32'(n_busy),      32'd1);
        check("mis_dout",   do_out,           32'hDEADBEEF);

        run_req(1'b0, 1'b1, 8'd252, 32'h0, 1'b1);
        check("wr252_ndone", 32'(n_done),      32'd1);
        check("wr252_busy",  32'(n_busy),      32'd5);
        check("wr252_a0",    32'(acc_addr[0]), 32'd252);
        check("wr252_a3",    32'(acc_addr[3]), 32'd255);
        check("wr252_data",  do_out,           32'h01020304);

        @(negedge clk);
        req = 1'b1; rw = 1'b1; size = 1'b1; addr = 8'd64; di = 32'h11223344;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        R = 1'b1;
        #1;
        check("abort_busy",   32'(busy),   32'h0);
        check("abort_mem_en", 32'(mem_en), 32'h0);
        check("abort_dout",   do_out,      32'h0);
        @(negedge clk);
        R = 1'b0;
        n_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_ndone", 32'(n_done),  32'd0);
        check("abort_ram64", 32'(ram[64]), 32'h11);
        check("abort_ram65", 32'(ram[65]), 32'h22);
        check("abort_ram66", 32'(ram[66]), 32'hA6);
        check("abort_ram67", 32'(ram[67]), 32'hA7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
